fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DSIZE, default 8, giving the FIFO data word width in bits.
REQ-002 SHALL have parameter CWIDTH, default 16, giving the width of each statistics counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all ports are in the FIFO read domain.
REQ-004 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rrst_n  input  1  asynchronous active-low reset.
REQ-006 rdata  input  DSIZE  FIFO head word; valid whenever rempty=0.
REQ-007 rempty  input  1  registered FIFO empty flag.
REQ-008 rinc  output  1  FIFO pop strobe, combinational.
REQ-009 flush  input  1  level request to discard buffered and queued words.
REQ-010 m_valid  output  1  stream word valid.
REQ-011 m_data  output  DSIZE  stream word, registered.
REQ-012 m_ready  input  1  downstream accept.
REQ-013 rd_count  output  CWIDTH  words delivered downstream, wrapping.
REQ-014 drop_count  output  CWIDTH  words discarded by flush, saturating.
REQ-015 busy  output  1  high while in state DRAIN.

Function
REQ-016 SHALL hold a 2-entry output buffer (head, tail) with occupancy cnt in the range 0..2; m_valid = (cnt != 0); m_data = head.
REQ-017 In state RUN, rinc SHALL be asserted when rempty=0 and either cnt<2, or cnt=2 with m_ready=1.
REQ-018 A pop (rinc=1) SHALL capture rdata in the same cycle; the word appears on m_data the next cycle (1-cycle latency) if the buffer was empty or the head was consumed.
REQ-019 A transfer SHALL occur on m_valid=1 and m_ready=1 at the rclk edge.
REQ-020 Buffer update rules, with simultaneous pop and transfer:
- cnt=1: head <= rdata, cnt stays 1.
- cnt=2: head <= tail, tail <= rdata, cnt stays 2.
REQ-021 Pop with no transfer SHALL write the first empty slot and increment cnt; transfer with no pop SHALL shift tail to head and decrement cnt.
REQ-022 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 The FSM SHALL have two states, RUN and DRAIN.
- RUN -> DRAIN on flush=1.
- DRAIN -> RUN when flush=0 and rempty=1 are sampled in the same cycle.
REQ-024 On entering DRAIN:
- cnt SHALL clear to 0, and m_valid SHALL be 0 from the next cycle.
- Buffered words SHALL NOT be counted as dropped.
- In the flush cycle itself, rinc SHALL be 0 and no transfer SHALL be counted.
REQ-025 In DRAIN, rinc SHALL equal ~rempty; each pop discards rdata and increments drop_count, saturating at all-ones.
REQ-026 In DRAIN, m_valid SHALL be 0 and m_ready SHALL be ignored.
REQ-027 rd_count SHALL increment by 1 per transfer and wrap modulo 2^CWIDTH.
REQ-028 flush held high SHALL keep the block in DRAIN indefinitely, popping whenever rempty=0.

Reset
REQ-029 While rrst_n=0, all state SHALL reset asynchronously to these values, with rinc=0:
- state=RUN, cnt=0, m_valid=0, m_data=0;
- rd_count=0, drop_count=0, busy=0.
REQ-030 Reset asserted mid-transfer SHALL discard buffered words without counting them; operation resumes on the first rclk edge after release.

Structure
REQ-031 Package fifo_rd_pkg SHALL hold the state enum (RUN, DRAIN) and the default DSIZE and CWIDTH constants.
REQ-032 The 2-entry buffer SHALL be sub-module fifo_rd_skid with push, pop, clear, data in and out, and cnt; fifo_rd_stream holds the FSM and the counters.

Verification
REQ-033 FIFO preloaded with 0x11, 0x22, 0x33 and m_ready=1 -> rinc high for 3 cycles; m_data = 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle after the first pop; rd_count=3.
REQ-034 m_ready=0 with 5 words queued -> exactly 2 pops, cnt=2, m_data held at the first word; raising m_ready then yields all 5 words in order with no gap.
REQ-035 m_ready toggling 1/0 every cycle over 20 words -> output order is identical to input order, with no duplicates or losses; rd_count=20.
REQ-036 Buffer full (2 words) plus 4 words in the FIFO, then flush pulsed for 1 cycle -> m_valid=0 the next cycle; 4 pops in DRAIN; drop_count=4; return to RUN once rempty=1; busy high throughout DRAIN.
REQ-037 rd_count preset near wrap (0xFFFE) via 3 transfers -> value reads 0x0001; drop_count driven past 0xFFFF -> holds 0xFFFF.
REQ-038 rrst_n asserted with cnt=2 and state=DRAIN -> all outputs reach their reset values immediately (asynchronously); the first word after release is delivered normally.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the FIFO read-side streaming block:
//   - default data width and statistics counter width
//   - read FSM state encoding (RUN / DRAIN)
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int CWIDTH_DEF = 16;

  // RUN   : words popped from the FIFO are forwarded downstream
  // DRAIN : words popped from the FIFO are discarded and counted
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Valid/ready stream carrying FIFO words downstream.
//   m_valid : word on m_data is valid
//   m_data  : stream word
//   m_ready : downstream accepts the word at the next rclk edge
// master drives valid/data, slave drives ready.
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
);

  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry output buffer (head, tail) sitting between the FIFO read port and
// the downstream stream. The head entry is always the word presented
// downstream.
// Ports:
//   rclk, rrst_n : read clock, asynchronous active-low reset
//   push         : write din into the buffer this cycle
//   pop          : head word is consumed this cycle
//   clear        : empty the buffer (takes priority over push/pop)
//   din          : word to write
//   dout         : head word
//   cnt          : occupancy, 0..2
// The caller never pushes into a full buffer without popping in the same
// cycle, and never pops an empty buffer.
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [DSIZE-1:0] din,
  output logic [DSIZE-1:0] dout,
  output logic [1:0]       cnt
);

  logic [DSIZE-1:0] head_p0;
  logic [DSIZE-1:0] tail_p0;
  logic [1:0]       cnt_p0;

  // ---- stage p0: buffer storage ----
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_p0  <= 2'd0;
      head_p0 <= '0;
      tail_p0 <= '0;
    end else if (clear) begin
      // Buffered words are abandoned; data registers keep their contents
      // but are invalid once cnt is zero.
      cnt_p0 <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          // Fill the first empty slot.
          if (cnt_p0 == 2'd0) begin
            head_p0 <= din;
          end else begin
            tail_p0 <= din;
          end
          cnt_p0 <= cnt_p0 + 2'd1;
        end
        2'b01: begin
          // Head consumed; the tail word (if any) moves up.
          if (cnt_p0 == 2'd2) begin
            head_p0 <= tail_p0;
          end
          cnt_p0 <= cnt_p0 - 2'd1;
        end
        2'b11: begin
          // Simultaneous consume and refill keeps occupancy constant.
          if (cnt_p0 == 2'd2) begin
            head_p0 <= tail_p0;
            tail_p0 <= din;
          end else begin
            head_p0 <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dout = head_p0;
  assign cnt  = cnt_p0;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Turns the read port of a FIFO (rdata/rempty/rinc) into a registered
// valid/ready stream, with a flush mechanism that discards queued words and
// statistics counters.
// Ports:
//   rclk, rrst_n : read-domain clock, asynchronous active-low reset
//   rdata        : FIFO head word, valid while rempty=0
//   rempty       : FIFO empty flag
//   rinc         : FIFO pop strobe (combinational)
//   flush        : level request to discard buffered and queued words
//   m_if         : stream master (m_valid, m_data, m_ready)
//   rd_count     : words delivered downstream, wraps
//   drop_count   : words discarded while draining, saturates at all-ones
//   busy         : high while draining
// In RUN, words are popped into a 2-entry skid buffer whenever it can accept
// one. A flush request empties the buffer and moves to DRAIN, where every
// available FIFO word is popped and counted as dropped; the block returns to
// RUN once flush is low and the FIFO reads empty in the same cycle.
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [DSIZE-1:0]    rdata,
  input  logic                rempty,
  output logic                rinc,
  input  logic                flush,
  fifo_rd_stream_if.master    m_if,
  output logic [CWIDTH-1:0]   rd_count,
  output logic [CWIDTH-1:0]   drop_count,
  output logic                busy
);

  localparam logic [0:0] ST_RUN   = RUN;
  localparam logic [0:0] ST_DRAIN = DRAIN;

  logic [0:0]       state_p0;
  logic [0:0]       state_nxt;
  logic [1:0]       cnt;
  logic [DSIZE-1:0] head_data;
  logic             in_run;
  logic             push;
  logic             xfer;
  logic             clear;
  logic             drop_pop;

  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CWIDTH-1:0] wrap_inc(input logic [CWIDTH-1:0] v);
    return v + 1'b1;
  endfunction

  assign in_run = (state_p0 == ST_RUN);

  // The flush cycle itself neither pops nor counts a transfer, so that the
  // words held in the buffer are abandoned cleanly.
  assign xfer = in_run && !flush && m_if.m_valid && m_if.m_ready;

  always_comb begin
    rinc = 1'b0;
    if (rrst_n) begin
      if (in_run) begin
        rinc = !flush && !rempty && ((cnt != 2'd2) || m_if.m_ready);
      end else begin
        rinc = !rempty;
      end
    end
  end

  assign push     = in_run && rinc;
  assign clear    = in_run && flush;
  assign drop_pop = !in_run && rinc;

  fifo_rd_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .push   (push),
    .pop    (xfer),
    .clear  (clear),
    .din    (rdata),
    .dout   (head_data),
    .cnt    (cnt)
  );

  assign m_if.m_valid = (cnt != 2'd0);
  assign m_if.m_data  = head_data;
  assign busy         = !in_run;

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      default: begin
        if (!flush && rempty) begin
          state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // ---- stage p0: FSM and statistics ----
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_p0   <= ST_RUN;
      rd_count   <= '0;
      drop_count <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (xfer) begin
        rd_count <= wrap_inc(rd_count);
      end
      if (drop_pop) begin
        drop_count <= sat_inc(drop_count);
      end
    end
  end

endmodule
